uart_rx_interface: RTL and testbench

Receive-side counterpart of the accumulator-to-UART transmit path. Deserialises 8N1 UART frames from the `RX` line, pairs consecutive bytes into 16-bit words (low byte first) and buffers them in a small FIFO. The BIP core, or a program loader, pops the words with a one-signal read handshake.

---
 rtl/uart_rx_interface_pkg.sv | 6 +
 rtl/uart_rx_fifo.sv | 48 ++++
 rtl/uart_rx_interface.sv | 140 ++++++++++++++
 tb/tb_uart_rx_interface.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/uart_rx_interface_pkg.sv
// uart_rx_interface_pkg: shared receiver FSM states and oversampling constants
package uart_rx_interface_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} rx_state_t;
    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous show-ahead FIFO with registered overrun pulse
// Ports: i_clk, i_reset (sync, active high), i_push/i_data write side,
// i_pop read side, o_data head word (0 while empty), o_empty, o_full,
// o_overrun one-cycle pulse when a push is dropped.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_overrun
);
    localparam int PTR_W = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_overrun;
    logic             w_push, w_pop;
    assign o_empty   = r_count == '0;
    assign o_full    = r_count == (PTR_W+1)'(DEPTH);
    assign w_pop     = i_pop & ~o_empty;
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign w_push    = i_push & (~o_full | w_pop);
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_overrun = r_overrun;
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count   <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
            r_overrun <= i_push & ~w_push;
        end
    end
endmodule

// File: rtl/uart_rx_interface.sv
// uart_rx_interface: 8N1 UART receiver pairing bytes into 16-bit words buffered in a FIFO
// Ports: i_clk, i_reset (sync, active high), i_rx serial line (idles high),
// i_rd pop request, o_data_out FIFO head word, o_empty, o_full,
// o_frame_err / o_overrun / o_par_err one-cycle error pulses.
// Build option: define UART_RX_PARITY_EN to receive an even-parity bit after the data.
module uart_rx_interface
    import uart_rx_interface_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rx,
    input  logic        i_rd,
    output logic [15:0] o_data_out,
    output logic        o_empty,
    output logic        o_full,
    output logic        o_frame_err,
    output logic        o_overrun,
    output logic        o_par_err
);
    localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = $clog2(DIV + 1);
`ifdef UART_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = ST_PARITY;
    logic w_par_done, r_par_bad, r_par_err;
`else
    localparam rx_state_t AFTER_DATA = ST_STOP;
`endif
    rx_state_t        r_state, w_state_next;
    logic             r_sync1, r_sync2, r_rx_last;
    logic [DIV_W-1:0] r_div_cnt;
    logic [3:0]       r_tick_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift, r_low;
    logic             r_half, r_frame_err;
    logic             w_tick, w_mid, w_end, w_bit_done, w_stop_done;
    logic             w_par_ok, w_accept, w_push;
    assign w_tick = r_div_cnt == DIV_W'(DIV - 1);
    assign w_mid  = w_tick & (r_tick_cnt == 4'(MID_SAMPLE));
    assign w_end  = w_tick & (r_tick_cnt == 4'(OVERSAMPLE - 1));
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_last <= 1'b1;
            r_div_cnt <= '0;
            r_state   <= ST_IDLE;
        end else begin
            r_sync1   <= i_rx;
            r_sync2   <= r_sync1;
            // line level at the previous tick, so the start edge is seen at tick resolution
            if (w_tick) r_rx_last <= r_sync2;
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            r_state   <= w_state_next;
        end
    end
    always_comb begin
        w_state_next = r_state;
        w_bit_done   = 1'b0;
        w_stop_done  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_done   = 1'b0;
`endif
        case (r_state)
            ST_IDLE:  w_state_next = (w_tick & r_rx_last & ~r_sync2) ? ST_START : ST_IDLE;
            ST_START: w_state_next = w_mid ? (r_sync2 ? ST_IDLE : ST_DATA) : ST_START;
            ST_DATA: begin
                w_bit_done   = w_end;
                w_state_next = (w_end && r_bit_cnt == 3'd7) ? AFTER_DATA : ST_DATA;
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                w_par_done   = w_end;
                w_state_next = w_end ? ST_STOP : ST_PARITY;
            end
`endif
            ST_STOP: begin
                w_stop_done  = w_end;
                w_state_next = w_end ? ST_IDLE : ST_STOP;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end
`ifdef UART_RX_PARITY_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_par_bad <= 1'b0;
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= w_par_done & (r_sync2 != ^r_shift);
            if (w_par_done) r_par_bad <= r_sync2 != ^r_shift;
        end
    end
    assign w_par_ok  = ~r_par_bad;
    assign o_par_err = r_par_err;
`else
    assign w_par_ok  = 1'b1;
    assign o_par_err = 1'b0;
`endif
    assign w_accept = w_stop_done & r_sync2 & w_par_ok;
    assign w_push   = w_accept & r_half;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_low       <= '0;
            r_half      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            // tick count restarts on every state change; 4-bit wrap handles the 16-tick bit period
            r_tick_cnt  <= (w_state_next != r_state) ? '0 : r_tick_cnt + 4'(w_tick);
            if (r_state == ST_START) r_bit_cnt <= '0;
            else if (w_bit_done) r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_bit_done) r_shift <= {r_sync2, r_shift[7:1]};
            if (w_accept & ~r_half) r_low <= r_shift;
            // accepted byte toggles the half-word flag; a rejected byte restarts pairing
            if (w_stop_done) r_half <= w_accept & ~r_half;
            r_frame_err <= w_stop_done & ~r_sync2;
        end
    end
    assign o_frame_err = r_frame_err;
    uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(16)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_push   (w_push),
        .i_data   ({r_shift, r_low}),
        .i_pop    (i_rd),
        .o_data   (o_data_out),
        .o_empty  (o_empty),
        .o_full   (o_full),
        .o_overrun(o_overrun)
    );
endmodule

// File: tb/tb_uart_rx_interface.sv
// tb_uart_rx_interface: directed self-checking bench for the UART word receiver
module tb_uart_rx_interface;
    localparam int BIT = 160;
    logic        clk = 1'b0, reset = 1'b1, rx = 1'b1, rd = 1'b0;
    logic [15:0] data_out;
    logic        empty, full, frame_err, overrun, par_err;
    int          n_cmp = 0, n_err = 0, n_fe = 0, n_ov = 0, n_pe = 0;
    logic [15:0] words [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    uart_rx_interface #(
        .CLK_FREQ  (1_600_000),
        .BAUD      (10_000),
        .FIFO_DEPTH(4)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_rx       (rx),
        .i_rd       (rd),
        .o_data_out (data_out),
        .o_empty    (empty),
        .o_full     (full),
        .o_frame_err(frame_err),
        .o_overrun  (overrun),
        .o_par_err  (par_err)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (frame_err) n_fe++;
        if (overrun) n_ov++;
        if (par_err) n_pe++;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic idle(input int n);
        #1 rx = 1'b1;
        repeat (n) @(posedge clk);
    endtask
    task automatic drive_bit(input logic b);
        #1 rx = b;
        repeat (BIT) @(posedge clk);
    endtask
    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^b);
`endif
        drive_bit(stop);
        idle(80);
    endtask
    task automatic send_word(input logic [15:0] w);
        send_frame(w[7:0], 1'b1);
        send_frame(w[15:8], 1'b1);
    endtask
    task automatic pop_check(input string tag, input logic [15:0] exp);
        @(negedge clk);
        check(tag, data_out, exp);
        rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
    endtask
`ifdef UART_RX_PARITY_EN
    task automatic send_par_frame(input logic [7:0] b, input logic par);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(par);
        drive_bit(1'b1);
        idle(80);
    endtask
`endif
    initial begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_data", data_out, 16'h0000);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_fe", frame_err, 1'b0);
        check("rst_ov", overrun, 1'b0);
        check("rst_pe", par_err, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(50);
        send_frame(8'h34, 1'b1);
        @(negedge clk);
        check("half_no_push", empty, 1'b1);
        send_frame(8'h12, 1'b1);
        @(negedge clk);
        check("pair_empty", empty, 1'b0);
        pop_check("word_1234", 16'h1234);
        @(negedge clk);
        check("pop_empty", empty, 1'b1);
        #1 rx = 1'b0;
        repeat (30) @(posedge clk);
        idle(400);
        @(negedge clk);
        check("glitch_empty", empty, 1'b1);
        send_word(16'h5678);
        pop_check("word_5678", 16'h5678);
        send_frame(8'h11, 1'b1);
        send_frame(8'hAA, 1'b0);
        @(negedge clk);
        check("fe_pulse", n_fe, 1);
        check("fe_empty", empty, 1'b1);
        send_word(16'hABCD);
        pop_check("word_abcd", 16'hABCD);
        check("fe_once", n_fe, 1);
        rd = 1'b1;
        repeat (3) @(posedge clk);
        #1 rd = 1'b0;
        @(negedge clk);
        check("rd_empty_ign", empty, 1'b1);
        check("rd_empty_full", full, 1'b0);
        for (int k = 0; k < 4; k++) send_word(words[k]);
        @(negedge clk);
        check("fill_full", full, 1'b1);
        check("fill_no_ov", n_ov, 0);
        send_word(words[4]);
        @(negedge clk);
        check("ov_pulse", n_ov, 1);
        check("ov_full", full, 1'b1);
        for (int k = 0; k < 4; k++) pop_check($sformatf("drain_%0d", k), words[k]);
        @(negedge clk);
        check("drain_empty", empty, 1'b1);
        check("drain_full", full, 1'b0);
        send_word(16'h4321);
        @(negedge clk);
        check("pre_rst_empty", empty, 1'b0);
        send_frame(8'h99, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        #1 rx = 1'b0;
        repeat (80) @(posedge clk);
        #1 reset = 1'b1;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_empty", empty, 1'b1);
        check("midrst_full", full, 1'b0);
        idle(400);
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        pop_check("word_0201", 16'h0201);
`ifdef UART_RX_PARITY_EN
        send_par_frame(8'h07, 1'b0);
        @(negedge clk);
        check("pe_pulse", n_pe, 1);
        check("pe_empty", empty, 1'b1);
        send_word(16'h1234);
        pop_check("pe_word_1234", 16'h1234);
`else
        check("pe_tied", n_pe, 0);
`endif
        @(negedge clk);
        check("final_empty", empty, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
